// File: rtl/image_window_ctrl.sv
// rtl/image_window_ctrl.sv - four-line ring buffer producing 3x3 pixel windows from a raster stream
module image_window_ctrl #(
  parameter int IMG_WIDTH = 512
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_pixel_data,
  input  logic        i_pixel_valid,
  output logic        o_ready,
  output logic [71:0] o_pixel_data,
  output logic        o_pixel_data_valid,
  output logic        o_intr
);

  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int CNT_W = $clog2(4 * IMG_WIDTH + 1);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(4 * IMG_WIDTH);
  localparam logic [CNT_W-1:0] READ_CNT = CNT_W'(3 * IMG_WIDTH);
  localparam logic [CNT_W-1:0] LINE_CNT = CNT_W'(IMG_WIDTH);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [COL_W-1:0] ONE_COL  = COL_W'(1);

  typedef enum logic {
    ST_IDLE,
    ST_READ
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       wr_sel_q, wr_sel_d;
  logic [1:0]       rd_sel_q, rd_sel_d;
  logic [COL_W-1:0] wr_col_q, wr_col_d;
  logic [COL_W-1:0] rd_col_q, rd_col_d;
  logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [71:0]      pix_q, pix_d;
  logic             valid_q, valid_d;
  logic             intr_q, intr_d;

  logic [7:0]       line_mem_q [4][IMG_WIDTH];

  logic             wr_en;
  logic             line_end;
  logic [1:0]       row_buf;
  logic [71:0]      win_next;

  assign o_ready            = (fill_cnt_q < FULL_CNT);
  assign wr_en              = i_pixel_valid & o_ready;
  assign line_end           = (state_q == ST_READ) && (rd_col_q == LAST_COL);
  assign o_pixel_data       = pix_q;
  assign o_pixel_data_valid = valid_q;
  assign o_intr             = intr_q;

  // Line storage; deliberately not reset so a reset costs no clear cycles.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      line_mem_q[wr_sel_q][wr_col_q] <= i_pixel_data;
    end
  end

  // Gather the 3x3 neighbourhood around rd_col from the three oldest lines, zero-padding the edges.
  always_comb begin
    win_next = '0;
    row_buf  = '0;
    for (int r = 0; r < 3; r++) begin
      row_buf = rd_sel_q + 2'(r);
      win_next[8*(r*3+0) +: 8] = (rd_col_q != '0) ? line_mem_q[row_buf][rd_col_q - ONE_COL] : 8'd0;
      win_next[8*(r*3+1) +: 8] = line_mem_q[row_buf][rd_col_q];
      win_next[8*(r*3+2) +: 8] = (rd_col_q != LAST_COL) ? line_mem_q[row_buf][rd_col_q + ONE_COL] : 8'd0;
    end
  end

  // Write pointer: column advances per accepted pixel, buffer advances on line wrap.
  always_comb begin
    wr_col_d = wr_col_q;
    wr_sel_d = wr_sel_q;
    if (wr_en) begin
      if (wr_col_q == LAST_COL) begin
        wr_col_d = '0;
        wr_sel_d = wr_sel_q + 2'd1;
      end else begin
        wr_col_d = wr_col_q + ONE_COL;
      end
    end
  end

  // Fill count: lines are released only at the end of a read so the writer cannot catch the reader.
  always_comb begin
    fill_cnt_d = fill_cnt_q;
    case ({wr_en, line_end})
      2'b10:   fill_cnt_d = fill_cnt_q + CNT_W'(1);
      2'b01:   fill_cnt_d = fill_cnt_q - LINE_CNT;
      2'b11:   fill_cnt_d = fill_cnt_q + CNT_W'(1) - LINE_CNT;
      default: fill_cnt_d = fill_cnt_q;
    endcase
  end

  // Read FSM: one window per cycle across a full line, then at least one idle cycle.
  always_comb begin
    state_d  = state_q;
    rd_col_d = rd_col_q;
    rd_sel_d = rd_sel_q;
    pix_d    = pix_q;
    valid_d  = 1'b0;
    intr_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rd_col_d = '0;
        if (fill_cnt_q >= READ_CNT) begin
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        pix_d   = win_next;
        valid_d = 1'b1;
        if (rd_col_q == LAST_COL) begin
          state_d  = ST_IDLE;
          rd_col_d = '0;
          rd_sel_d = rd_sel_q + 2'd1;
          intr_d   = 1'b1;
        end else begin
          rd_col_d = rd_col_q + ONE_COL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and output registers; reset discards any in-flight window.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      wr_sel_q   <= '0;
      wr_col_q   <= '0;
      rd_sel_q   <= '0;
      rd_col_q   <= '0;
      fill_cnt_q <= '0;
      pix_q      <= '0;
      valid_q    <= 1'b0;
      intr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_sel_q   <= wr_sel_d;
      wr_col_q   <= wr_col_d;
      rd_sel_q   <= rd_sel_d;
      rd_col_q   <= rd_col_d;
      fill_cnt_q <= fill_cnt_d;
      pix_q      <= pix_d;
      valid_q    <= valid_d;
      intr_q     <= intr_d;
    end
  end

endmodule

// File: tb/tb_image_window_ctrl.sv
// tb/tb_image_window_ctrl.sv - directed self-checking bench for image_window_ctrl
module tb_image_window_ctrl;

  localparam int W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pix;
  logic        pv;
  logic        rdy;
  logic [71:0] od;
  logic        odv;
  logic        intr;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;
  int t0;

  logic [71:0] win_log [$];
  int          win_cyc [$];
  int          intr_log [$];

  localparam logic [71:0] W0_EXP = {8'd10, 8'd9, 8'd0, 8'd6, 8'd5, 8'd0, 8'd2, 8'd1, 8'd0};
  localparam logic [71:0] W3_EXP = {8'd0, 8'd12, 8'd11, 8'd0, 8'd8, 8'd7, 8'd0, 8'd4, 8'd3};

  image_window_ctrl #(.IMG_WIDTH(W)) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_pixel_data       (pix),
    .i_pixel_valid      (pv),
    .o_ready            (rdy),
    .o_pixel_data       (od),
    .o_pixel_data_valid (odv),
    .o_intr             (intr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture windows and interrupts away from the active edge.
  always @(negedge clk) begin
    if (odv) begin
      win_log.push_back(od);
      win_cyc.push_back(cyc);
    end
    if (intr) intr_log.push_back(cyc);
  end

  // Ramp image: line L, column x holds L*W + x + 1; out-of-range columns are zero.
  function automatic logic [71:0] model_win(input int top, input int c);
    logic [71:0] w;
    int x;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 3; j++) begin
        x = c - 1 + j;
        if (x >= 0 && x < W) w[8*(r*3+j) +: 8] = 8'((top + r) * W + x + 1);
      end
    end
    return w;
  endfunction

  function automatic logic [71:0] get_win(input int i);
    if (win_log.size() > i) return win_log[i];
    return 'x;
  endfunction

  function automatic int get_wcyc(input int i);
    if (win_cyc.size() > i) return win_cyc[i];
    return -1;
  endfunction

  function automatic int get_icyc(input int i);
    if (intr_log.size() > i) return intr_log[i];
    return -1;
  endfunction

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    win_log.delete();
    win_cyc.delete();
    intr_log.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pv  = 1'b0;
    pix = 8'd0;
    repeat (3) tick();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic stream(input int n, input int first);
    for (int i = 0; i < n; i++) begin
      pv  = 1'b1;
      pix = 8'(first + i);
      tick();
    end
    pv  = 1'b0;
    pix = 8'd0;
  endtask

  logic [19:0] rdy_hist;
  int          idx;
  int          budget;
  logic        acc;

  initial begin
    rst = 1'b1;
    pv  = 1'b0;
    pix = 8'd0;
    repeat (3) tick();
    check("reset_ready", rdy, 1'b1);
    check("reset_valid", odv, 1'b0);
    check("reset_intr", intr, 1'b0);
    check("reset_data", od, '0);
    rst = 1'b0;
    clear_logs();

    // Basic window and latency
    t0 = cyc;
    stream(12, 1);
    repeat (25) tick();
    check("basic_count", win_log.size(), 4);
    check("basic_w0", get_win(0), W0_EXP);
    check("basic_w1", get_win(1), model_win(0, 1));
    check("basic_w2", get_win(2), model_win(0, 2));
    check("basic_w3", get_win(3), W3_EXP);
    check("lat_first_valid", get_wcyc(0), t0 + 14);
    check("lat_last_valid", get_wcyc(3), t0 + 17);
    check("basic_intr_count", intr_log.size(), 1);
    check("lat_intr", get_icyc(0), t0 + 17);

    // Backpressure with continuous valid
    do_reset();
    t0 = cyc;
    for (int i = 0; i < 20; i++) begin
      pv  = 1'b1;
      pix = 8'(i + 1);
      rdy_hist[i] = rdy;
      tick();
    end
    pv  = 1'b0;
    pix = 8'd0;
    repeat (10) tick();
    check("bp_ready_hist", rdy_hist, 20'hEFFFF);
    check("bp_count", win_log.size(), 8);
    check("bp_read2_start", get_wcyc(4), t0 + 19);
    check("bp_read2_w0", get_win(4), model_win(1, 0));
    check("bp_read2_w3", get_win(7), model_win(1, 3));
    check("bp_fill_end", dut.fill_cnt_q, 11);
    check("bp_wr_col", dut.wr_col_q, 3);
    check("bp_wr_sel_wrap", dut.wr_sel_q, 0);

    // Write coinciding with line-end decrement
    do_reset();
    stream(12, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      pv  = 1'b1;
      pix = 8'(13 + i);
      if (i == 3) check("simul_fill_before", dut.fill_cnt_q, 15);
      tick();
    end
    pv  = 1'b0;
    pix = 8'd0;
    check("simul_fill_after", dut.fill_cnt_q, 12);

    // Ring wrap over seven lines with handshaking
    do_reset();
    idx    = 0;
    budget = 400;
    while (idx < 7 * W && budget > 0) begin
      pv  = 1'b1;
      pix = 8'(idx + 1);
      acc = rdy;
      tick();
      if (acc) idx++;
      budget--;
    end
    pv  = 1'b0;
    pix = 8'd0;
    check("ring_all_accepted", idx, 7 * W);
    repeat (30) tick();
    check("ring_count", win_log.size(), 5 * W);
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < W; c++) begin
        check($sformatf("ring_row%0d_col%0d", r, c), get_win(r * W + c), model_win(r, c));
      end
    end
    check("ring_intr_count", intr_log.size(), 5);
    check("ring_rd_sel", dut.rd_sel_q, 1);
    check("ring_wr_sel", dut.wr_sel_q, 3);
    check("ring_fill", dut.fill_cnt_q, 8);

    // Reset asserted during window 1
    do_reset();
    t0 = cyc;
    stream(12, 1);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("midrst_data", od, '0);
    check("midrst_valid", odv, 1'b0);
    check("midrst_intr", intr, 1'b0);
    check("midrst_ready", rdy, 1'b1);
    repeat (3) tick();
    rst = 1'b0;
    repeat (20) tick();
    check("midrst_no_more_windows", win_log.size(), 1);
    clear_logs();
    t0 = cyc;
    stream(12, 1);
    repeat (25) tick();
    check("post_rst_count", win_log.size(), 4);
    check("post_rst_w0", get_win(0), W0_EXP);
    check("post_rst_w3", get_win(3), W3_EXP);
    check("post_rst_first_valid", get_wcyc(0), t0 + 14);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
